// File: rtl/lsu_mem_access.sv
// lsu_mem_access
// Execute/memory stage behind the load/store decoder. Forms the effective
// address, issues one valid/ready memory request at a time, aligns store data
// and byte enables, and sign/zero-extends returned load data for writeback.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   When defined, adds output misalign_err; misaligned half/word accesses skip
//   memory and pulse misalign_err one cycle after acceptance.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      decoded op handshake (ready only while idle)
//   is_load, zero_ext,
//   is_nop, size, rd         decoded op fields
//   rs1_val, rs2_val, imm    base, store data, signed 12-bit offset
//   mem_req_*/mem_addr/
//   mem_we/mem_be/mem_wdata  single-outstanding memory request
//   mem_resp_valid/mem_rdata response (one per accepted request)
//   wb_valid/wb_rd/wb_data   load writeback (wb_valid is a one-cycle pulse)
//   timeout_err              one-cycle pulse when a request is abandoned
//   misalign_err             (macro only) one-cycle misalignment trap pulse
//
// State table:
//   IDLE | waiting for a decoded op; in_ready high
//   REQ  | request presented, waiting for mem_req_ready
//   WAIT | request accepted, waiting for mem_resp_valid or timeout

module lsu_mem_access #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        is_load,
   input  logic        zero_ext,
   input  logic        is_nop,
   input  logic [1:0]  size,
   input  logic [4:0]  rd,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic [11:0] imm,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
`ifdef LSU_MISALIGN_TRAP_EN
   output logic        misalign_err,
`endif
   output logic        timeout_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] ea;
   logic [3:0]  new_be;
   logic [31:0] new_wdata;
   logic        misaligned;
   logic        accept;
   logic        capture;
   logic        resp_done;
   logic        tmo_hit;
   logic [31:0] wait_cnt;

   logic        op_load;
   logic        op_zext;
   logic [1:0]  op_size;
   logic [1:0]  op_off;
   logic [4:0]  op_rd;

   logic [31:0] byte_lane;
   logic [31:0] half_lane;
   logic [31:0] load_ext;

   assign ea            = rs1_val + {{20{imm[11]}}, imm};
   assign in_ready      = (state_q == IDLE);
   assign mem_req_valid = (state_q == REQ);
   assign accept        = in_valid && in_ready && !is_nop;

`ifdef LSU_MISALIGN_TRAP_EN
   assign misaligned = ((size == 2'b01) && ea[0]) ||
                       (size[1] && (ea[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   // Comparing against TIMEOUT-1 only matters when the timeout is enabled;
   // the wrapped value for TIMEOUT==0 is masked off.
   assign tmo_hit = (TIMEOUT != 0) && (wait_cnt == TIMEOUT - 1);

   always_comb begin
      new_be    = 4'b1111;
      new_wdata = rs2_val;
      case (size)
         2'b00: begin
            new_be    = 4'b0001 << ea[1:0];
            new_wdata = {4{rs2_val[7:0]}};
         end
         2'b01: begin
            new_be    = ea[1] ? 4'b1100 : 4'b0011;
            new_wdata = {2{rs2_val[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      capture     = 1'b0;
      resp_done   = 1'b0;
      timeout_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept && !misaligned) begin
               capture = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (mem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            // A response arriving in the final allowed cycle still wins.
            if (mem_resp_valid) begin
               resp_done = 1'b1;
               state_d   = IDLE;
            end else if (tmo_hit) begin
               timeout_err = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      byte_lane = mem_rdata >> {op_off, 3'b000};
      half_lane = mem_rdata >> {op_off[1], 4'b0000};
      case (op_size)
         2'b00:   load_ext = op_zext ? {24'd0, byte_lane[7:0]}
                                     : {{24{byte_lane[7]}}, byte_lane[7:0]};
         2'b01:   load_ext = op_zext ? {16'd0, half_lane[15:0]}
                                     : {{16{half_lane[15]}}, half_lane[15:0]};
         default: load_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         op_load   <= 1'b0;
         op_zext   <= 1'b0;
         op_size   <= 2'b00;
         op_off    <= 2'b00;
         op_rd     <= 5'd0;
         mem_addr  <= 32'd0;
         mem_we    <= 1'b0;
         mem_be    <= 4'd0;
         mem_wdata <= 32'd0;
         wait_cnt  <= 32'd0;
         wb_valid  <= 1'b0;
         wb_rd     <= 5'd0;
         wb_data   <= 32'd0;
      end else begin
         state_q  <= state_d;
         wb_valid <= 1'b0;
         if (capture) begin
            op_load   <= is_load;
            op_zext   <= zero_ext;
            op_size   <= size;
            op_off    <= ea[1:0];
            op_rd     <= rd;
            mem_addr  <= {ea[31:2], 2'b00};
            mem_we    <= !is_load;
            mem_be    <= new_be;
            mem_wdata <= new_wdata;
         end
         if ((state_q == REQ) && mem_req_ready) begin
            wait_cnt <= 32'd0;
         end else if (state_q == WAIT) begin
            wait_cnt <= wait_cnt + 32'd1;
         end
         if (resp_done && op_load && (op_rd != 5'd0)) begin
            wb_valid <= 1'b1;
            wb_rd    <= op_rd;
            wb_data  <= load_ext;
         end
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= accept && misaligned;
      end
   end
`endif

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Execute/memory stage directly downstream of the load/store decoder; consumes its decoded fields plus register-file operand values.
- Computes effective address, drives a single-outstanding valid/ready memory request, and aligns store data and byte enables.
- Extracts, sign/zero-extends and writes back load data; one access in flight at a time.

Parameters:
- TIMEOUT, 256, max cycles in WAIT before abort; 0 disables timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded op present
- in_ready  out  1  stage can accept (high only in IDLE)
- is_load  in  1  1=load, 0=store
- zero_ext  in  1  zero-extend load result
- is_nop  in  1  op is a bubble
- size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- rd  in  5  load destination
- rs1_val  in  32  base register value
- rs2_val  in  32  store data register value
- imm  in  12  signed offset
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  word-aligned address {ea[31:2],2'b00}
- mem_we  out  1  1=write
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_resp_valid  in  1  response/ack (one per accepted request, loads and stores)
- mem_rdata  in  32  read data, valid with mem_resp_valid
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  5  writeback register
- wb_data  out  32  extended load result
- timeout_err  out  1  one-cycle pulse on abort

Behaviour:
- Reset: state=IDLE; in_ready=1 after reset releases; mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata, wb_valid, wb_rd, wb_data, timeout_err, wait counter all 0.
- ea = rs1_val + sign_extend(imm); 32-bit wrap-around, no overflow detection.
- IDLE: on in_valid && in_ready: if is_nop, drop (no request, no wb, stay IDLE); else register op, go REQ.
- REQ: mem_req_valid=1; addr/we/be/wdata stable until mem_req_ready; on handshake go WAIT, clear counter. mem_resp_valid in REQ is ignored (memory must not respond in acceptance cycle).
- WAIT: counter increments each cycle. On mem_resp_valid: go IDLE. For loads with rd!=0, next cycle wb_valid=1, wb_rd=rd, wb_data=extended lane. Stores and rd==0 loads produce no wb. If TIMEOUT!=0 and counter reaches TIMEOUT-1 without response: timeout_err pulses 1 cycle, go IDLE, no wb; later stray responses are ignored in IDLE.
- Latency: accept cycle 0 -> mem_req_valid cycle 1; response cycle N -> wb_valid and in_ready cycle N+1.
- Stores: byte be=4'b0001<<ea[1:0], wdata={4{rs2_val[7:0]}}; half be=ea[1]?1100:0011, wdata={2{rs2_val[15:0]}}; word be=1111, wdata=rs2_val.
- Loads: mem_we=0, mem_be as for store of same size. Byte lane=rdata>>(8*ea[1:0]), half lane=rdata>>(16*ea[1]); extend bit 7/15 unless zero_ext; word returned as is.
- Misaligned (without macro): half ignores ea[0], word ignores ea[1:0]; access proceeds.
- wb outputs hold last value except wb_valid, which is a pulse.
- Async reset mid-operation: immediate return to IDLE, all outputs to reset values, pending op discarded.

Optional Feature:
- LSU_MISALIGN_TRAP_EN: adds output misalign_err (1). Half with ea[0]=1 or word with ea[1:0]!=0 skips memory, stays IDLE, pulses misalign_err one cycle after accept, no wb. Without macro: port absent, misaligned handled as above.

Test Plan:
- Load byte signed: rs1=0x1000, imm=0x003, rdata=0x80FFFFFF, zero_ext=0, rd=5 -> mem_addr=0x1000, be=1000, wb_data=0xFFFFFF80, wb_rd=5.
- Store half: rs1=0x2000, imm=0xFFE (-2), rs2=0x1234ABCD -> mem_addr=0x1FFC, be=1100, wdata=0xABCDABCD, we=1, no wb.
- Backpressure: mem_req_ready low 5 cycles -> mem_req_valid and payload held stable, in_ready=0 throughout.
- NOP and rd=0: is_nop=1 -> no mem_req_valid; load rd=0 -> request issued, no wb_valid.
- Timeout: TIMEOUT=8, no response -> timeout_err pulse 8 cycles after request handshake, in_ready=1 next cycle; late response ignored.
- Reset in WAIT: assert rst -> outputs zero immediately; subsequent response produces no wb.
